// File: rtl/core_seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// core_seq_pkg : shared types, defaults and helpers for core_seq_ctrl.  Rev 1.0
// ---------------------------------------------------------------------------
package core_seq_pkg;

    typedef enum logic [0:0] {
        SEQ_RUN  = 1'b0,
        SEQ_HALT = 1'b1
    } seq_state_t;

    localparam int CORE_SEQ_STAGES     = 4;
    localparam int CORE_SEQ_TRAP_STAGE = 1;

    // Index width that never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/core_seq_wdog.sv
`default_nettype none
// ---------------------------------------------------------------------------
// core_seq_wdog : saturating stall counter with sticky hang flag.  Rev 1.0
// ---------------------------------------------------------------------------
module core_seq_wdog #(
    parameter int WDOG_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic flag
);

    localparam logic [WDOG_W-1:0] C_MAX = {WDOG_W{1'b1}};

    logic [WDOG_W-1:0] r_cnt;
    logic              r_flag;
    logic [WDOG_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + {{(WDOG_W-1){1'b0}}, 1'b1};

    // Counter restarts whenever the stage is not stalled; the flag only on clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_flag <= 1'b0;
        end else if (clr) begin
            r_cnt  <= '0;
            r_flag <= 1'b0;
        end else if (!inc) begin
            r_cnt  <= '0;
        end else if (r_cnt != C_MAX) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == C_MAX) begin
                r_flag <= 1'b1;
            end
        end
    end

    assign flag = r_flag;

endmodule

`default_nettype wire

// File: rtl/core_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// core_seq_ctrl : NUM_STAGES one-hot stage sequencer with trap, debug halt,
// retire counter; watchdog built when CORE_SEQ_WDOG_EN is defined.  Rev 1.0
// ---------------------------------------------------------------------------
module core_seq_ctrl
    import core_seq_pkg::*;
#(
    parameter int NUM_STAGES = CORE_SEQ_STAGES,
    parameter int TRAP_STAGE = CORE_SEQ_TRAP_STAGE,
    parameter int CNT_W      = 32,
    parameter int WDOG_W     = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUM_STAGES-1:0]               stage_ready_i,
    input  logic                                trap_i,
    input  logic                                halt_req_i,
    input  logic                                wdog_clr_i,
    output logic [NUM_STAGES-1:0]               stage_en_o,
    output logic [idx_width(NUM_STAGES)-1:0]    stage_idx_o,
    output logic                                retire_o,
    output logic [CNT_W-1:0]                    instret_o,
    output logic                                halted_o,
    output logic                                wdog_o
);

    localparam int                IDX_W    = idx_width(NUM_STAGES);
    localparam logic [IDX_W-1:0]  C_LAST   = IDX_W'(NUM_STAGES - 1);
    localparam logic [IDX_W-1:0]  C_TRAP   = IDX_W'(TRAP_STAGE);
    localparam logic [IDX_W-1:0]  C_ONE    = IDX_W'(1);
    localparam logic [CNT_W-1:0]  C_CNT1   = CNT_W'(1);

    seq_state_t             r_state, w_state_next;
    logic [IDX_W-1:0]       r_idx, w_idx_next;
    logic [NUM_STAGES-1:0]  r_stage_en, w_stage_en_next;
    logic                   r_retire, w_retire_next;
    logic [CNT_W-1:0]       r_instret, w_instret_next;
    logic                   r_halted;
    logic                   w_stall;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= SEQ_RUN;
            r_idx      <= '0;
            r_stage_en <= NUM_STAGES'(1);
            r_retire   <= 1'b0;
            r_instret  <= '0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_idx      <= w_idx_next;
            r_stage_en <= w_stage_en_next;
            r_retire   <= w_retire_next;
            r_instret  <= w_instret_next;
            r_halted   <= (w_state_next == SEQ_HALT);
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_idx_next      = r_idx;
        w_retire_next   = 1'b0;
        w_instret_next  = r_instret;
        w_stage_en_next = '0;
        case (r_state)
            SEQ_RUN: begin
                if (trap_i) begin
                    w_idx_next = C_TRAP;
                end else if (stage_ready_i[r_idx]) begin
                    if (r_idx != C_LAST) begin
                        w_idx_next = r_idx + C_ONE;
                    end else begin
                        w_retire_next  = 1'b1;
                        w_instret_next = r_instret + C_CNT1;
                        w_idx_next     = '0;
                        if (halt_req_i) begin
                            w_state_next = SEQ_HALT;
                        end
                    end
                end
            end
            SEQ_HALT: begin
                w_idx_next = '0;
                if (!halt_req_i) begin
                    w_state_next = SEQ_RUN;
                end
            end
            default: begin
                w_state_next = SEQ_RUN;
                w_idx_next   = '0;
            end
        endcase
        for (int k = 0; k < NUM_STAGES; k++) begin
            w_stage_en_next[k] = (w_state_next == SEQ_RUN) && (w_idx_next == IDX_W'(k));
        end
    end

    // A stall is a running cycle that keeps the same stage without a trap.
    assign w_stall = (r_state == SEQ_RUN) && (w_state_next == SEQ_RUN) &&
                     !trap_i && (w_idx_next == r_idx);

`ifdef CORE_SEQ_WDOG_EN
    core_seq_wdog #(
        .WDOG_W (WDOG_W)
    ) u_wdog (
        .clk  (clk_i),
        .rst  (rst_i),
        .inc  (w_stall),
        .clr  (wdog_clr_i),
        .flag (wdog_o)
    );
`else
    logic w_unused_wdog;
    assign w_unused_wdog = wdog_clr_i ^ w_stall;
    assign wdog_o        = 1'b0;
`endif

    assign stage_en_o  = r_stage_en;
    assign stage_idx_o = r_idx;
    assign retire_o    = r_retire;
    assign instret_o   = r_instret;
    assign halted_o    = r_halted;

endmodule

`default_nettype wire
